// File: rtl/div_exp_unit.sv
// div_exp_unit: exponent datapath for the FP16 divider.
// Computes E = expA - expB + BIAS - dec in two pipeline stages (carry-save,
// then resolve), saturates it into an exponent field and flags ovf/unf.
//
// Handshake: a beat moves across an interface on a rising edge where
// valid & ready are both high. The sender holds its valid and data stable
// until that edge. in_valid never depends on in_ready. in_ready is taken
// combinationally from out_ready through the stage enables.
module div_exp_unit #(
  parameter int EXP_BITS = 5,
  parameter int BIAS     = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [EXP_BITS-1:0] expA,
  input  logic [EXP_BITS-1:0] expB,
  input  logic                dec,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [EXP_BITS-1:0] exp,
  output logic                ovf,
  output logic                unf
);

  // Two guard bits give a signed range wide enough for the whole FP16
  // span of E, which is [-17, 46].
  localparam int EW = EXP_BITS + 2;
  // -expB is written as ~expB + 1, so the +1 is folded into the constant.
  localparam logic [EW-1:0] K_BASE = EW'(BIAS + 1);
  // Largest finite biased exponent plus one: all ones in the field.
  localparam logic [EW-2:0] E_SAT = (EW-1)'((1 << EXP_BITS) - 1);

  logic          s2_en;
  logic          s1_en;

  logic          s1_valid_q;
  logic [EW-1:0] s1_sum_q;
  logic [EW-1:0] s1_carry_q;
  logic [EW-1:0] s1_sum_d;
  logic [EW-1:0] s1_carry_d;

  logic                s2_valid_q;
  logic [EXP_BITS-1:0] exp_q;
  logic                ovf_q;
  logic                unf_q;
  logic [EXP_BITS-1:0] exp_d;
  logic                ovf_d;
  logic                unf_d;

  logic [EW-1:0] op_a;
  logic [EW-1:0] op_b;
  logic [EW-1:0] op_k;
  logic [EW-1:0] e_sum;
  logic          e_neg;

  // Each stage may advance when it is empty or when its consumer drains it.
  assign s2_en    = ~s2_valid_q | out_ready;
  assign s1_en    = ~s1_valid_q | s2_en;
  assign in_ready = s1_en;

  // Stage 1 next state: per-bit 3:2 compression of expA, ~expB and the
  // bias constant, all sign-extended to EW bits.
  always_comb begin
    op_a       = {2'b00, expA};
    op_b       = ~{2'b00, expB};
    op_k       = K_BASE - {{(EW-1){1'b0}}, dec};
    s1_sum_d   = op_a ^ op_b ^ op_k;
    s1_carry_d = (op_a & op_b) | (op_a & op_k) | (op_b & op_k);
  end

  // Stage 1 registers: capture the carry-save pair on an input transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_carry_q <= '0;
    end else if (s1_en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sum_q   <= s1_sum_d;
        s1_carry_q <= s1_carry_d;
      end
    end
  end

  // Stage 2 next state: resolve the carry-save pair and saturate.
  always_comb begin
    e_sum = s1_sum_q + (s1_carry_q << 1);
    e_neg = e_sum[EW-1];
    unf_d = e_neg | (e_sum == '0);
    ovf_d = ~e_neg & (e_sum[EW-2:0] >= E_SAT);
    exp_d = e_sum[EXP_BITS-1:0];
    if (ovf_d) begin
      exp_d = '1;
    end else if (unf_d) begin
      exp_d = '0;
    end
  end

  // Stage 2 registers: result held stable while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      exp_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        exp_q <= exp_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign exp       = exp_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule

// File: doc/div_exp_unit.md
Name: div_exp_unit

Overview:
- Exponent datapath for the FP16 divider: the inverse of the multiplier's biased exponent sum.
- Computes the biased quotient exponent E = expA - expB + BIAS - dec.
  - dec is the normalization decrement from the mantissa divider; it is 1 when the mantissa quotient is < 1.
- Two-stage pipeline with valid/ready handshakes on both sides.
- Sits between operand unpack and the divider's pack/round stage.

Parameters:
- EXP_BITS, 5, exponent field width.
- BIAS, 15, exponent bias; must equal 2^(EXP_BITS-1)-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept an operand beat.
- expA  input  EXP_BITS  biased dividend exponent.
- expB  input  EXP_BITS  biased divisor exponent.
- dec  input  1  normalization decrement.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- exp  output  EXP_BITS  saturated biased quotient exponent.
- ovf  output  1  E >= 2^EXP_BITS-1 (result is infinity).
- unf  output  1  E <= 0 (result is subnormal or zero; handled downstream).

Behaviour:
- Reset (asynchronous, active-high):
  - Both stage valids clear.
  - All stage data registers clear.
  - out_valid=0, exp=0, ovf=0, unf=0.
  - in_ready=1 in the first cycle after reset deasserts.
- Handshake definitions:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
  - in_valid must not depend on in_ready.
  - expA, expB and dec are sampled only on an input transfer.
- Stage 1 (carry-save):
  - On input transfer, registers per bit the sum and carry of expA[i], ~expB[i] and the constant (BIAS+1-dec).
  - The bias constant is one's-complement corrected for the -expB term.
  - Sets s1_valid.
- Stage 2 (resolve):
  - Adds s1 sum and shifted carry in a signed (EXP_BITS+2)-bit adder to obtain E.
  - FP16 range: E in [-17, 46].
  - Registers exp, ovf, unf and s2_valid (s2_valid = out_valid).
- Saturation:
  - E >= 31: ovf=1, exp=31.
  - E <= 0: unf=1, exp=0.
  - Otherwise exp=E[4:0], both flags 0.
  - ovf and unf are never both set.
- Flow control:
  - s2_en = ~s2_valid | out_ready.
  - s1_en = ~s1_valid | s2_en.
  - in_ready = s1_en.
  - The combinational out_ready->in_ready path is permitted.
  - When a stage's enable is high and its upstream is empty, its valid clears.
  - Throughput: 1 beat per cycle with out_ready held high.
  - Latency: 2 cycles from input transfer to out_valid.
- Backpressure:
  - While out_valid=1 and out_ready=0, exp/ovf/unf are held stable.
  - At most 2 beats are buffered; in_ready falls when both stages are full.
  - No beat is dropped or duplicated; order is preserved.
- Simultaneous events: an output transfer and an input transfer in the same cycle with both stages full shifts the pipeline by one and accepts the new beat.
- Reset mid-operation: all in-flight beats are discarded; outputs return to reset values immediately.
- Out of scope (flagged upstream):
  - Special exponents 0 and 31 are not classified here.
  - Inputs are treated arithmetically.

Test Plan:
- expA=15, expB=15, dec=0, out_ready=1 -> exactly 2 cycles after the transfer: out_valid=1, exp=15, ovf=0, unf=0. Repeat with dec=1 -> exp=14.
- Saturation:
  - expA=16, expB=0, dec=0 -> E=31: exp=31, ovf=1.
  - expA=30, expB=1, dec=0 -> E=44: exp=31, ovf=1.
  - expA=16, expB=0, dec=1 -> exp=30, ovf=0.
- Underflow:
  - expA=1, expB=16, dec=0 -> E=0: exp=0, unf=1.
  - expA=2, expB=16, dec=0 -> exp=1, unf=0.
  - expA=0, expB=31, dec=1 -> E=-17: exp=0, unf=1.
- Streaming and backpressure:
  - 8 back-to-back beats with out_ready=1 -> 8 consecutive results in order, in_ready constantly 1.
  - Then out_ready=0 for 5 cycles -> in_ready=0 after 2 further accepts, outputs stable; release -> remaining beats drain in order, none lost.
- Simultaneous: both stages full, out_ready=1 and in_valid=1 in the same cycle -> one beat out, one beat in, out_valid stays 1.
- Reset: assert rst asynchronously mid-clock with 2 beats in flight -> out_valid=0, exp=0, ovf=0, unf=0 before the next edge; after release, the first new beat appears 2 cycles after its transfer.
